// File: rtl/display_scanner.sv
// Multiplexed seven-segment scan driver: double-buffered character codes, per-digit
// blanking gap, and a shadow->active copy that only happens at the frame wrap.
module display_scanner #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500,
  localparam int IDX_W       = $clog2(NUM_DIGITS)
) (
  input  logic                  Clk,
  input  logic                  nReset,
  input  logic                  wr_en,
  input  logic [IDX_W-1:0]      wr_addr,
  input  logic [4:0]            wr_data,
  input  logic                  commit,
  output logic [4:0]            digit,
  output logic [NUM_DIGITS-1:0] an,
  output logic                  frame_tick,
  output logic                  commit_pend
);

  // state   | meaning
  // S_BLANK | first BLANK_CYCLES of a slot, all anodes off, code precharged
  // S_ON    | remainder of the slot, anode of idx driven low

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam logic [4:0] BLANK_CODE = 5'd31;

  typedef enum logic {S_BLANK, S_ON} state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [4:0]            shadow_q [NUM_DIGITS];
  logic [4:0]            shadow_d [NUM_DIGITS];
  logic [4:0]            active_q [NUM_DIGITS];
  logic [4:0]            active_d [NUM_DIGITS];
  logic                  pend_q, pend_d;
  logic [4:0]            digit_q, digit_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic                  tick_q;
  logic                  slot_end, wrap;

  always_comb begin
    slot_end = (cnt_q == CNT_W'(REFRESH_DIV - 1));
    wrap     = slot_end && (idx_q == IDX_W'(NUM_DIGITS - 1));

    cnt_d = slot_end ? '0 : cnt_q + CNT_W'(1);

    idx_d = idx_q;
    if (wrap)          idx_d = '0;
    else if (slot_end) idx_d = idx_q + IDX_W'(1);

    state_d = state_q;
    if (slot_end)
      state_d = S_BLANK;
    else if (state_q == S_BLANK && cnt_q == CNT_W'(BLANK_CYCLES - 1))
      state_d = S_ON;

    // The copy uses pre-edge shadow contents, so a same-edge write waits for the next commit.
    active_d = active_q;
    pend_d   = pend_q | commit;
    if (wrap) begin
      pend_d = 1'b0;
      if (pend_q || commit) active_d = shadow_q;
    end

    shadow_d = shadow_q;
    if (wr_en && (int'(wr_addr) < NUM_DIGITS)) shadow_d[wr_addr] = wr_data;

    // Outputs are computed from next-state values so they line up with the slot counter.
    digit_d = active_d[idx_d];
    an_d    = (state_d == S_ON) ? ~(NUM_DIGITS'(1) << idx_d) : '1;
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state_q  <= S_BLANK;
      cnt_q    <= '0;
      idx_q    <= '0;
      shadow_q <= '{default: BLANK_CODE};
      active_q <= '{default: BLANK_CODE};
      pend_q   <= 1'b0;
      digit_q  <= BLANK_CODE;
      an_q     <= '1;
      tick_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      pend_q   <= pend_d;
      digit_q  <= digit_d;
      an_q     <= an_d;
      tick_q   <= wrap;
    end
  end

  assign digit       = digit_q;
  assign an          = an_q;
  assign frame_tick  = tick_q;
  assign commit_pend = pend_q;

endmodule

// File: tb/tb_display_scanner.sv
// Self-checking bench for display_scanner: a cycle-count based reference model for a
// 4-digit build, plus a 3-digit build for out-of-range write addresses.
module tb_display_scanner;
  localparam int N  = 4;
  localparam int RD = 8;
  localparam int BL = 2;
  localparam int FR = N * RD;

  logic       Clk = 1'b0;
  logic       nReset = 1'b0;
  logic       wr_en = 1'b0;
  logic [1:0] wr_addr = '0;
  logic [4:0] wr_data = '0;
  logic       commit = 1'b0;
  logic [4:0] digit;
  logic [3:0] an;
  logic       frame_tick;
  logic       commit_pend;

  logic       w3_en = 1'b0;
  logic [1:0] w3_addr = '0;
  logic [4:0] w3_data = '0;
  logic       c3 = 1'b0;
  logic [4:0] digit3;
  logic [2:0] an3;
  logic       tick3;
  logic       pend3;

  display_scanner #(.NUM_DIGITS(N), .REFRESH_DIV(RD), .BLANK_CYCLES(BL)) dut (
    .Clk(Clk), .nReset(nReset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .commit(commit), .digit(digit), .an(an), .frame_tick(frame_tick), .commit_pend(commit_pend)
  );

  display_scanner #(.NUM_DIGITS(3), .REFRESH_DIV(RD), .BLANK_CYCLES(BL)) dut3 (
    .Clk(Clk), .nReset(nReset), .wr_en(w3_en), .wr_addr(w3_addr), .wr_data(w3_data),
    .commit(c3), .digit(digit3), .an(an3), .frame_tick(tick3), .commit_pend(pend3)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int failures = 0;

  // Reference model: t = rising edges since reset release.
  int         t;
  logic [4:0] sh_m  [N];
  logic [4:0] act_m [N];
  bit         pend_m;

  function automatic logic [3:0] exp_an();
    int cnt = t % RD;
    int idx = (t / RD) % N;
    if (cnt < BL) return 4'hF;
    return ~(4'b0001 << idx);
  endfunction

  function automatic logic [4:0] exp_digit();
    return act_m[(t / RD) % N];
  endfunction

  function automatic logic exp_tick();
    return (t > 0) && (t % FR == 0);
  endfunction

  task automatic model_reset();
    t = 0;
    pend_m = 1'b0;
    for (int i = 0; i < N; i++) begin
      sh_m[i]  = 5'd31;
      act_m[i] = 5'd31;
    end
  endtask

  task automatic tick();
    bit wrap;
    @(posedge Clk);
    wrap = ((t + 1) % FR == 0);
    if (wrap) begin
      if (pend_m || commit) act_m = sh_m;
      pend_m = 1'b0;
    end else if (commit) begin
      pend_m = 1'b1;
    end
    if (wr_en && int'(wr_addr) < N) sh_m[wr_addr] = wr_data;
    t++;
    #1;
  endtask

  task automatic do_reset();
    nReset = 1'b0;
    wr_en = 1'b0; commit = 1'b0; w3_en = 1'b0; c3 = 1'b0;
    model_reset();
    repeat (2) @(posedge Clk);
    #1 nReset = 1'b1;
  endtask

  // Never more than one anode low on either build.
  always @(negedge Clk) begin
    if (nReset) begin
      checks++;
      if ($countones(~an) > 1) begin
        failures++; $display("FAIL onehot_an got=%b req=at_most_one_low", an);
      end
      checks++;
      if ($countones(~an3) > 1) begin
        failures++; $display("FAIL onehot_an3 got=%b req=at_most_one_low", an3);
      end
    end
  end

  task automatic test_reset();
    do_reset();
    checks++; if (an !== 4'hF)       begin failures++; $display("FAIL reset_an got=%b req=1111", an); end
    checks++; if (digit !== 5'd31)   begin failures++; $display("FAIL reset_digit got=%0d req=31", digit); end
    checks++; if (frame_tick !== 0)  begin failures++; $display("FAIL reset_tick got=%b req=0", frame_tick); end
    checks++; if (commit_pend !== 0) begin failures++; $display("FAIL reset_pend got=%b req=0", commit_pend); end
    for (int c = 1; c <= 70; c++) begin
      tick();
      checks++; if (an !== exp_an()) begin failures++; $display("FAIL scan_an t=%0d got=%b req=%b", t, an, exp_an()); end
      checks++; if (digit !== 5'd31) begin failures++; $display("FAIL scan_digit t=%0d got=%0d req=31", t, digit); end
      checks++; if (frame_tick !== exp_tick()) begin failures++; $display("FAIL scan_tick t=%0d got=%b req=%b", t, frame_tick, exp_tick()); end
      if (c == 1 || c == 2 || c == 7 || c == 9 || c == 10 || c == 15 || c == 32 || c == 64) begin
        logic [3:0] req_an;
        logic       req_tk;
        req_an = (c == 1 || c == 9) ? 4'b1111 : (c == 2 || c == 7) ? 4'b1110 :
                 (c == 10 || c == 15) ? 4'b1101 : 4'b1111;
        req_tk = (c == 32 || c == 64);
        checks++; if (an !== req_an) begin failures++; $display("FAIL fixed_an c=%0d got=%b req=%b", c, an, req_an); end
        checks++; if (frame_tick !== req_tk) begin failures++; $display("FAIL fixed_tick c=%0d got=%b req=%b", c, frame_tick, req_tk); end
      end
    end
  endtask

  task automatic test_write_no_commit();
    logic [4:0] vals [4];
    vals[0] = 5'd18; vals[1] = 5'd16; vals[2] = 5'd20; vals[3] = 5'd22;
    for (int a = 0; a < 4; a++) begin
      wr_en = 1'b1; wr_addr = 2'(a); wr_data = vals[a];
      tick();
    end
    wr_en = 1'b0;
    for (int c = 0; c < 2 * FR; c++) begin
      tick();
      checks++; if (digit !== 5'd31) begin failures++; $display("FAIL nocommit_digit t=%0d got=%0d req=31", t, digit); end
      checks++; if (commit_pend !== 1'b0) begin failures++; $display("FAIL nocommit_pend t=%0d got=%b req=0", t, commit_pend); end
    end
  endtask

  task automatic test_commit();
    logic [4:0] vals [4];
    vals[0] = 5'd18; vals[1] = 5'd16; vals[2] = 5'd20; vals[3] = 5'd22;
    for (int k = 0; k < FR && (t % FR) != 5; k++) tick();
    commit = 1'b1; tick(); commit = 1'b0;
    for (int k = 0; k < FR && (t % FR) != 0; k++) begin
      checks++; if (commit_pend !== 1'b1) begin failures++; $display("FAIL pend_hold t=%0d got=%b req=1", t, commit_pend); end
      tick();
    end
    checks++; if (frame_tick !== 1'b1)  begin failures++; $display("FAIL commit_wrap_tick t=%0d got=%b req=1", t, frame_tick); end
    checks++; if (commit_pend !== 1'b0) begin failures++; $display("FAIL pend_clear t=%0d got=%b req=0", t, commit_pend); end
    checks++; if (digit !== 5'd18)      begin failures++; $display("FAIL first_blank_digit got=%0d req=18", digit); end
    for (int c = 0; c < FR; c++) begin
      if (an !== 4'hF) begin
        int idx = (t / RD) % N;
        checks++; if (digit !== vals[idx]) begin failures++; $display("FAIL commit_digit idx=%0d got=%0d req=%0d", idx, digit, vals[idx]); end
      end
      checks++; if (an !== exp_an()) begin failures++; $display("FAIL commit_an t=%0d got=%b req=%b", t, an, exp_an()); end
      tick();
    end
  endtask

  task automatic test_commit_on_wrap();
    for (int k = 0; k < FR && ((t + 1) % FR) != 0; k++) tick();
    commit = 1'b1; wr_en = 1'b1; wr_addr = 2'd2; wr_data = 5'd5;
    tick();
    commit = 1'b0; wr_en = 1'b0;
    checks++; if (commit_pend !== 1'b0) begin failures++; $display("FAIL wrapcommit_pend got=%b req=0", commit_pend); end
    checks++; if (frame_tick !== 1'b1)  begin failures++; $display("FAIL wrapcommit_tick got=%b req=1", frame_tick); end
    for (int c = 0; c < FR; c++) begin
      if (((t / RD) % N) == 2 && (t % RD) >= BL) begin
        checks++; if (digit !== 5'd20) begin failures++; $display("FAIL wrapcommit_old t=%0d got=%0d req=20", t, digit); end
      end
      tick();
    end
    commit = 1'b1; tick(); commit = 1'b0;
    for (int k = 0; k < FR && (t % FR) != 0; k++) tick();
    for (int c = 0; c < FR; c++) begin
      if (((t / RD) % N) == 2 && (t % RD) >= BL) begin
        checks++; if (digit !== 5'd5) begin failures++; $display("FAIL wrapcommit_new t=%0d got=%0d req=5", t, digit); end
      end
      checks++; if (digit !== exp_digit()) begin failures++; $display("FAIL wrapcommit_model t=%0d got=%0d req=%0d", t, digit, exp_digit()); end
      tick();
    end
  endtask

  task automatic test_out_of_range();
    logic [4:0] v3 [3];
    v3[0] = 5'd3; v3[1] = 5'd9; v3[2] = 5'd12;
    do_reset();
    for (int a = 0; a < 3; a++) begin
      w3_en = 1'b1; w3_addr = 2'(a); w3_data = v3[a];
      tick();
    end
    w3_en = 1'b1; w3_addr = 2'd3; w3_data = 5'd7;
    c3 = 1'b1; tick();
    w3_en = 1'b0; c3 = 1'b0;
    checks++; if (pend3 !== 1'b1) begin failures++; $display("FAIL oor_pend got=%b req=1", pend3); end
    repeat (30) tick();
    w3_en = 1'b1; w3_addr = 2'd3; w3_data = 5'd0; c3 = 1'b1;
    tick();
    w3_en = 1'b0; c3 = 1'b0;
    repeat (30) tick();
    for (int c = 0; c < 24; c++) begin
      int         idx = (t / RD) % 3;
      logic [2:0] req_an;
      req_an = ((t % RD) < BL) ? 3'b111 : ~(3'b001 << idx);
      checks++; if (an3 !== req_an)     begin failures++; $display("FAIL oor_an t=%0d got=%b req=%b", t, an3, req_an); end
      checks++; if (digit3 !== v3[idx]) begin failures++; $display("FAIL oor_digit t=%0d got=%0d req=%0d", t, digit3, v3[idx]); end
      checks++; if (tick3 !== ((t % 24) == 0)) begin failures++; $display("FAIL oor_tick t=%0d got=%b", t, tick3); end
      tick();
    end
  endtask

  task automatic test_reset_mid_scan();
    do_reset();
    for (int a = 0; a < 4; a++) begin
      wr_en = 1'b1; wr_addr = 2'(a); wr_data = 5'(a + 1);
      tick();
    end
    wr_en = 1'b0; commit = 1'b1; tick(); commit = 1'b0;
    for (int k = 0; k < 100 && t != FR + 13; k++) tick();
    checks++; if (an !== 4'b1101) begin failures++; $display("FAIL mid_pre_an got=%b req=1101", an); end
    checks++; if (digit !== 5'd2) begin failures++; $display("FAIL mid_pre_digit got=%0d req=2", digit); end
    #2 nReset = 1'b0;
    #1;
    checks++; if (an !== 4'hF)     begin failures++; $display("FAIL async_an got=%b req=1111", an); end
    checks++; if (digit !== 5'd31) begin failures++; $display("FAIL async_digit got=%0d req=31", digit); end
    do_reset();
    commit = 1'b1; tick(); commit = 1'b0;
    for (int c = 0; c < 2 * FR; c++) begin
      checks++; if (an !== exp_an())    begin failures++; $display("FAIL restart_an t=%0d got=%b req=%b", t, an, exp_an()); end
      checks++; if (digit !== 5'd31)    begin failures++; $display("FAIL restart_digit t=%0d got=%0d req=31", t, digit); end
      tick();
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 800; c++) begin
      wr_en   = ($urandom_range(0, 2) == 0);
      wr_addr = 2'($urandom_range(0, 3));
      wr_data = 5'($urandom_range(0, 31));
      commit  = ($urandom_range(0, 19) == 0);
      tick();
      checks++; if (an !== exp_an())        begin failures++; $display("FAIL rnd_an t=%0d got=%b req=%b", t, an, exp_an()); end
      checks++; if (digit !== exp_digit())  begin failures++; $display("FAIL rnd_digit t=%0d got=%0d req=%0d", t, digit, exp_digit()); end
      checks++; if (frame_tick !== exp_tick()) begin failures++; $display("FAIL rnd_tick t=%0d got=%b req=%b", t, frame_tick, exp_tick()); end
      checks++; if (commit_pend !== pend_m) begin failures++; $display("FAIL rnd_pend t=%0d got=%b req=%b", t, commit_pend, pend_m); end
    end
    wr_en = 1'b0; commit = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_write_no_commit();
    test_commit();
    test_commit_on_wrap();
    test_out_of_range();
    test_reset_mid_scan();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

endmodule
